// File: rtl/rv32i_mem_arbiter_pkg.sv
// rtl/rv32i_mem_arbiter_pkg.sv - shared types and constants for the unified memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_IF = 1'b0,
        OWNER_DM = 1'b1
    } mem_arb_owner_t;

    // Legal read latency window of the memory port, in cycles.
    localparam int unsigned RD_LATENCY_MIN = 1;
    localparam int unsigned RD_LATENCY_MAX = 4;

    // Wide enough to hold RD_LATENCY_MAX.
    localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// rtl/rv32i_mem_arbiter_if.sv - fetch/load-store request, response and memory port bundle
interface rv32i_mem_arbiter_if;

    // Instruction-fetch requester
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;

    // Load/store requester
    logic        dm_req_valid;
    logic        dm_req_ready;
    logic [31:0] dm_addr;
    logic        dm_wr_ena;
    logic [31:0] dm_wr_data;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_data;

    // Single-ported memory
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;

    // Requesters and memory model side
    modport master (
        output if_req_valid, if_addr,
        output dm_req_valid, dm_addr, dm_wr_ena, dm_wr_data,
        output mem_rd_data,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_data,
        input  mem_addr, mem_wr_data, mem_wr_ena
    );

    // Arbiter side
    modport slave (
        input  if_req_valid, if_addr,
        input  dm_req_valid, dm_addr, dm_wr_ena, dm_wr_data,
        input  mem_rd_data,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output dm_req_ready, dm_rsp_valid, dm_rsp_data,
        output mem_addr, mem_wr_data, mem_wr_ena
    );

endinterface

// File: rtl/rv32i_mem_arbiter_grant.sv
// rtl/rv32i_mem_arbiter_grant.sv - combinational two-way one-hot grant
import mem_arb_pkg::*;

module mem_arb_grant (
    input  logic if_valid,
    input  logic dm_valid,
    input  logic ena,
    input  logic idle,
    input  logic favour_dm,
    output logic if_gnt,
    output logic dm_gnt
);

    logic can_grant;

    // Data wins unless fetch is also valid and the pointer favours fetch.
    always_comb begin
        can_grant = ena && idle;
        dm_gnt    = can_grant && dm_valid && (!if_valid || favour_dm);
        if_gnt    = can_grant && if_valid && !dm_gnt;
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - unified I/D memory arbiter; MEM_ARB_ROUND_ROBIN_EN selects round-robin
import mem_arb_pkg::*;

module rv32i_mem_arbiter #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    rv32i_mem_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("rv32i_mem_arbiter: RD_LATENCY out of range");
    end

    mem_arb_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_arb_owner_t   owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      if_data_q, if_data_d;
    logic [31:0]      dm_data_q, dm_data_d;

    logic idle;
    logic favour_dm;
    logic if_gnt;
    logic dm_gnt;
    logic rsp_fire;
    logic if_rsp_fire;
    logic dm_rsp_fire;
    logic rd_accept;

    // Nothing is granted while reset is held.
    assign idle = (state_q == ARB_IDLE) && !rst;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;  // 1 = data favoured on the next conflict

    // Hand priority to the other requester after every grant.
    always_comb begin
        rr_d = rr_q;
        if (if_gnt || dm_gnt) begin
            rr_d = if_gnt;
        end
    end

    // Round-robin pointer register; data favoured out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign favour_dm = rr_q;
`else
    assign favour_dm = 1'b1;
`endif

    mem_arb_grant u_grant (
        .if_valid  (bus.if_req_valid),
        .dm_valid  (bus.dm_req_valid),
        .ena       (ena),
        .idle      (idle),
        .favour_dm (favour_dm),
        .if_gnt    (if_gnt),
        .dm_gnt    (dm_gnt)
    );

    assign rd_accept   = if_gnt || (dm_gnt && !bus.dm_wr_ena);
    assign rsp_fire    = (state_q == ARB_RD_WAIT) && (cnt_q == CNT_ONE) && !rst;
    assign if_rsp_fire = rsp_fire && (owner_q == OWNER_IF);
    assign dm_rsp_fire = rsp_fire && (owner_q == OWNER_DM);

    // Next-state: capture a read on accept, count down, deliver and capture data at count 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        if_data_d = if_data_q;
        dm_data_d = dm_data_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (rd_accept) begin
                    state_d = ARB_RD_WAIT;
                    cnt_d   = CNT_LOAD;
                    owner_d = dm_gnt ? OWNER_DM : OWNER_IF;
                    addr_d  = dm_gnt ? bus.dm_addr : bus.if_addr;
                end
            end
            ARB_RD_WAIT: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ARB_IDLE;
                end
            end
        endcase
        if (if_rsp_fire) begin
            if_data_d = bus.mem_rd_data;
        end
        if (dm_rsp_fire) begin
            dm_data_d = bus.mem_rd_data;
        end
    end

    // State, counter, owner, address and held response data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            cnt_q     <= '0;
            owner_q   <= OWNER_IF;
            addr_q    <= '0;
            if_data_q <= '0;
            dm_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            if_data_q <= if_data_d;
            dm_data_q <= dm_data_d;
        end
    end

    assign bus.if_req_ready = if_gnt;
    assign bus.dm_req_ready = dm_gnt;
    assign bus.if_rsp_valid = if_rsp_fire;
    assign bus.dm_rsp_valid = dm_rsp_fire;
    // Response data follows memory in the response cycle, then holds.
    assign bus.if_rsp_data  = if_rsp_fire ? bus.mem_rd_data : if_data_q;
    assign bus.dm_rsp_data  = dm_rsp_fire ? bus.mem_rd_data : dm_data_q;

    // Memory port: registered address while a read is in flight, else the granted request.
    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        bus.mem_wr_ena  = 1'b0;
        if (!rst && state_q == ARB_RD_WAIT) begin
            bus.mem_addr = addr_q;
        end else if (dm_gnt) begin
            bus.mem_addr = bus.dm_addr;
            if (bus.dm_wr_ena) begin
                bus.mem_wr_data = bus.dm_wr_data;
                bus.mem_wr_ena  = 1'b1;
            end
        end else if (if_gnt) begin
            bus.mem_addr = bus.if_addr;
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - randomized bench with transaction-level reference model
module tb_rv32i_mem_arbiter;

    localparam int LAT  = 3;
    localparam int NCYC = 800;

    logic clk = 1'b0;
    logic rst;
    logic ena;

    always #5 clk = ~clk;

    rv32i_mem_arbiter_if bus_if ();

    rv32i_mem_arbiter #(.RD_LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (bus_if)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Requester state: a request stays posted until the model accepts it.
    bit          if_pend = 0;
    logic [31:0] if_a    = '0;
    bit          dm_pend = 0;
    logic [31:0] dm_a    = '0;
    bit          dm_we   = 0;
    logic [31:0] dm_wd   = '0;

    // Reference model state
    bit          busy      = 0;
    int          resp_cyc  = 0;
    bit          own_dm    = 0;
    logic [31:0] rd_addr   = '0;
    bit          favour_dm = 1;
    logic [31:0] last_if   = '0;
    logic [31:0] last_dm   = '0;

    // Addresses seen on the memory port, for the latency-delayed memory model.
    logic [31:0] hist [8];

    function automatic logic [31:0] mem_hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00700093;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_inputs(input int c);
        bit force_req;
        force_req = (c < 80) || (c >= 695 && c < 706);
        rst = (c < 2) || (c >= 80 && c < 690 && $urandom_range(0, 49) == 0);
        if (c < 80)                 ena = 1'b1;
        else if (c >= 700 && c < 706) ena = 1'b0;
        else                        ena = ($urandom_range(0, 5) != 0);
        if (!if_pend && (force_req || $urandom_range(0, 2) == 0)) begin
            if_pend = 1;
            if_a    = 32'($urandom_range(0, 255)) << 2;
        end
        if (!dm_pend && (force_req || $urandom_range(0, 2) == 0)) begin
            dm_pend = 1;
            dm_a    = 32'h100 + (32'($urandom_range(0, 255)) << 2);
            dm_we   = (c >= 80 && c < 695) ? ($urandom_range(0, 1) == 1) : 1'b0;
            dm_wd   = $urandom;
        end
        bus_if.if_req_valid = if_pend;
        bus_if.if_addr      = if_a;
        bus_if.dm_req_valid = dm_pend;
        bus_if.dm_addr      = dm_a;
        bus_if.dm_wr_ena    = dm_we;
        bus_if.dm_wr_data   = dm_wd;
        bus_if.mem_rd_data  = (cyc >= LAT) ? mem_hash(hist[(cyc - LAT) % 8]) : 32'h0;
    endtask

    task automatic model_and_check();
        logic        e_ifr, e_dmr, e_ifv, e_dmv, e_we;
        logic [31:0] e_addr, e_wd;
        bit          win_dm;
        e_ifr = 0; e_dmr = 0; e_ifv = 0; e_dmv = 0; e_we = 0;
        e_addr = '0; e_wd = '0;
        if (rst) begin
            // outputs quiet; held data unchanged until the reset edge
        end else if (busy) begin
            e_addr = rd_addr;
            if (cyc == resp_cyc) begin
                if (own_dm) begin
                    e_dmv   = 1;
                    last_dm = mem_hash(rd_addr);
                end else begin
                    e_ifv   = 1;
                    last_if = mem_hash(rd_addr);
                end
                busy = 0;
            end
        end else if (ena && (if_pend || dm_pend)) begin
            win_dm = dm_pend && (!if_pend || favour_dm);
            if (win_dm) begin
                e_dmr  = 1;
                e_addr = dm_a;
                if (dm_we) begin
                    e_we = 1;
                    e_wd = dm_wd;
                end else begin
                    busy = 1; resp_cyc = cyc + LAT; own_dm = 1; rd_addr = dm_a;
                end
            end else begin
                e_ifr  = 1;
                e_addr = if_a;
                busy = 1; resp_cyc = cyc + LAT; own_dm = 0; rd_addr = if_a;
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            favour_dm = !win_dm;
`endif
        end

        check_eq("if_req_ready", 32'(bus_if.if_req_ready), 32'(e_ifr));
        check_eq("dm_req_ready", 32'(bus_if.dm_req_ready), 32'(e_dmr));
        check_eq("if_rsp_valid", 32'(bus_if.if_rsp_valid), 32'(e_ifv));
        check_eq("dm_rsp_valid", 32'(bus_if.dm_rsp_valid), 32'(e_dmv));
        check_eq("if_rsp_data",  bus_if.if_rsp_data, last_if);
        check_eq("dm_rsp_data",  bus_if.dm_rsp_data, last_dm);
        check_eq("mem_addr",     bus_if.mem_addr, e_addr);
        check_eq("mem_wr_data",  bus_if.mem_wr_data, e_wd);
        check_eq("mem_wr_ena",   32'(bus_if.mem_wr_ena), 32'(e_we));

        if (e_ifr) if_pend = 0;
        if (e_dmr) dm_pend = 0;
        if (rst) begin
            busy = 0; favour_dm = 1; last_if = '0; last_dm = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) hist[i] = '0;
        rst = 1'b1;
        ena = 1'b0;
        bus_if.if_req_valid = 1'b0;
        bus_if.if_addr      = '0;
        bus_if.dm_req_valid = 1'b0;
        bus_if.dm_addr      = '0;
        bus_if.dm_wr_ena    = 1'b0;
        bus_if.dm_wr_data   = '0;
        bus_if.mem_rd_data  = '0;
        @(posedge clk);
        for (int c = 0; c < NCYC; c++) begin
            #1;
            drive_inputs(c);
            @(negedge clk);
            model_and_check();
            hist[cyc % 8] = bus_if.mem_addr;
            cyc++;
            @(posedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Shares the single-ported unified instruction/data memory of the multicycle RV32I core between two requesters: the instruction-fetch path (read-only) and the load/store path (read/write). It grants one request at a time with valid/ready handshakes and drives the memory port. It waits a fixed number of cycles for read data, then returns that data to the requester that issued the read. It sits between the core's control FSM and the memory, so the core no longer hardwires `mem_addr = PC`.

## Interface
- `RD_LATENCY`, 1: cycles from address sampling to valid `mem_rd_data`; legal range 1..4.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  when low, no new grants; an in-flight read still completes.
- `if_req_valid`  in  1  fetch request.
- `if_req_ready`  out  1  fetch request accepted this cycle.
- `if_addr`  in  32  fetch address.
- `if_rsp_valid`  out  1  one-cycle pulse; `if_rsp_data` valid.
- `if_rsp_data`  out  32  fetched word.
- `dm_req_valid`  in  1  data request.
- `dm_req_ready`  out  1  data request accepted this cycle.
- `dm_addr`  in  32  data address.
- `dm_wr_ena`  in  1  1 = store, 0 = load.
- `dm_wr_data`  in  32  store data.
- `dm_rsp_valid`  out  1  one-cycle pulse for loads only.
- `dm_rsp_data`  out  32  load data.
- `mem_addr`  out  32  memory address.
- `mem_wr_data`  out  32  memory write data.
- `mem_wr_ena`  out  1  memory write strobe.
- `mem_rd_data`  in  32  memory read data.

## Operation
- States:
  - IDLE: can grant.
  - RD_WAIT: read in flight; a latency counter counts down from RD_LATENCY.
- Grant in IDLE: when `ena`=1 and at least one valid is high, exactly one ready goes high in the same cycle, combinationally. The winner is chosen by the arbitration policy (see Configuration).
- Accepted store:
  - `mem_addr`=`dm_addr`, `mem_wr_data`=`dm_wr_data`, `mem_wr_ena`=1 for that one cycle.
  - State stays IDLE.
  - No response pulse.
- Accepted read (fetch, or load):
  - `mem_addr` is driven with the request address in the accept cycle.
  - The address and owner ID are registered; `mem_addr` holds the registered address throughout RD_WAIT.
  - The counter is loaded with RD_LATENCY; state goes to RD_WAIT.
- RD_WAIT:
  - Both readies are 0 and `mem_wr_ena` is 0.
  - The counter decrements each cycle.
  - When the counter reaches 1, the owner's `*_rsp_valid` pulses for one cycle and `*_rsp_data` = `mem_rd_data` sampled that cycle. State returns to IDLE.
- Response data holds its last value until the next response; only the valid signal pulses.
- There is no response back-pressure; requesters must accept responses.
- Idle outputs: `mem_addr`=0, `mem_wr_data`=0, `mem_wr_ena`=0.
- Addresses pass through unmodified; there is no alignment check.

## Timing
- Reset values:
  - State IDLE; counter 0; owner = fetch.
  - Round-robin pointer favours data.
  - All ready and rsp_valid outputs 0; `*_rsp_data`=0.
  - `mem_addr`, `mem_wr_data` 0; `mem_wr_ena`=0.
- Read latency: accept at cycle N → `rsp_valid` at cycle N+RD_LATENCY.
- Read throughput: one read per RD_LATENCY+1 cycles. Store throughput: one per cycle.
- Requests arriving during RD_WAIT wait; the valid signal must stay high with stable payload until ready.
- Simultaneous valids in IDLE are resolved by policy; the loser sees ready=0 and retries the next cycle.
- `ena` low during RD_WAIT: the counter keeps running and the response is still delivered.
- `ena` low in IDLE: both readies are 0.
- Reset in RD_WAIT: the in-flight read is dropped, no response pulse, and the block is in IDLE the next cycle.
- A response cycle and a new grant never share a cycle. The earliest new grant is the cycle after `rsp_valid`.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - Two-way round-robin.
  - The pointer flips to the other requester after every grant, reads and stores alike.
  - On conflict, the requester the pointer favours wins.
- Not defined:
  - Fixed priority: data beats fetch.
  - No pointer flop.

## Structure
- `mem_arb_pkg` holds:
  - the `mem_arb_state_t` enum {ARB_IDLE, ARB_RD_WAIT};
  - the `mem_arb_owner_t` enum {OWNER_IF, OWNER_DM};
  - the RD_LATENCY legality bounds constant.
- One sub-module, `mem_arb_grant`: combinational two-way grant logic. Its inputs are both valids, `ena`, the idle flag and the pointer; its outputs are one-hot grants. The pointer flop lives in the parent under the macro.

## Test plan
1. RD_LATENCY=1, fetch only, `if_addr`=0x0000_0004, mem returns 0x00700093 → `if_req_ready` at cycle N, `if_rsp_valid` at N+1 with data 0x00700093, `dm_rsp_valid` stays 0.
2. Store `dm_addr`=0x100, data 0xDEADBEEF → `mem_wr_ena`=1 for exactly one cycle with matching address/data. A second store the next cycle is accepted back-to-back, and no response pulses occur.
3. Both valid every cycle, fixed priority, loads → all grants go to dm, with fetch starved. With `MEM_ARB_ROUND_ROBIN_EN`, grants alternate dm, if, dm, if.
4. RD_LATENCY=3, load at 0x200 → `mem_addr` holds 0x200 for cycles N..N+3, readies are 0 for N+1..N+3, `dm_rsp_valid` fires at N+3.
5. `rst` asserted at N+1 of a RD_LATENCY=3 read → no `rsp_valid` ever fires for it, and all outputs are 0 at N+2.
6. `ena`=0 with both valids high for 5 cycles → no ready and no `mem_wr_ena`. Deasserting `ena` mid-RD_WAIT still produces the response on schedule.
